// File: rtl/timer_dev.sv
// -----------------------------------------------------------------------------
// timer_dev
//   Programmable countdown timer on the CPU data bus. Holds CTRL, PRESET and
//   COUNT registers and runs an IDLE/LOAD/CNT/INT state machine. When the
//   count expires it raises int_flag, which becomes irq when CTRL.IM is set.
//   One-shot mode clears CTRL.EN on expiry. Auto-reload mode emits a
//   one-cycle pulse and then reloads from PRESET.
//
// Ports
//   clk     in   1   system clock, rising edge
//   reset   in   1   synchronous active-low reset
//   addr    in   32  byte address (word offset = addr[3:2])
//   byteen  in   4   byte write enables, 4'b0000 = no write
//   wdata   in   32  write data, lane aligned
//   rdata   out  32  combinational read data, 0 when not hit
//   irq     out  1   interrupt request (int_flag & CTRL.IM)
//
// Register map (addr[3:2])
//   0 CTRL   [0]=EN [2:1]=MODE [3]=IM, upper bits read 0
//   1 PRESET reload value
//   2 COUNT  current count, read-only
//   3 --     reads 0
// -----------------------------------------------------------------------------
module timer_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    state_t      state, state_nxt;
    ctrl_t       ctrl;
    logic [31:0] preset;
    logic [31:0] count, count_nxt;
    logic        int_flag, flag_nxt;
    logic        fsm_clr_en;

    logic        hit;
    logic        wr;
    logic [1:0]  off;
    logic        wr_ctrl;
    logic        wr_preset;
    ctrl_t       ctrl_wr;
    logic [31:0] preset_wr;

    // addr[1:0] is irrelevant for word-wide registers
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr        = hit && (byteen != 4'b0000);
    assign off       = addr[3:2];
    assign wr_ctrl   = wr && (off == OFF_CTRL);
    assign wr_preset = wr && (off == OFF_PRESET);

    // CTRL only stores byte lane 0, bits [3:0]
    assign ctrl_wr = byteen[0] ? ctrl_t'(wdata[3:0]) : ctrl;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            preset_wr[8*i +: 8] = byteen[i] ? wdata[8*i +: 8] : preset[8*i +: 8];
        end
    end

    // ---------------------------------------------------------------- FSM
    // Operates on registered CTRL/PRESET, so a CPU write is seen one edge
    // later. Clearing EN in any state sends the FSM to IDLE with COUNT held.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        flag_nxt   = int_flag;
        fsm_clr_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl.en) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (!ctrl.en) begin
                    state_nxt = S_IDLE;
                end else begin
                    count_nxt = preset;
                    state_nxt = S_CNT;
                end
            end
            S_CNT: begin
                if (!ctrl.en) begin
                    state_nxt = S_IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    // PRESET of 0 or 1 both expire after one CNT cycle
                    count_nxt = 32'd0;
                    flag_nxt  = 1'b1;
                    state_nxt = S_INT;
                end
            end
            S_INT: begin
                if (!ctrl.en) begin
                    state_nxt = S_IDLE;
                end else if (ctrl.mode == 2'b01) begin
                    flag_nxt  = 1'b0;
                    state_nxt = S_LOAD;
                end else begin
                    // one-shot: int_flag stays set until software writes CTRL
                    fsm_clr_en = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            int_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (wr_preset) preset <= preset_wr;
            // a software CTRL write overrides the FSM's EN clear and acks irq
            if (wr_ctrl) begin
                ctrl     <= ctrl_wr;
                int_flag <= 1'b0;
            end else begin
                if (fsm_clr_en) ctrl.en <= 1'b0;
                int_flag <= flag_nxt;
            end
        end
    end

    // ---------------------------------------------------------------- read
    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            case (off)
                OFF_CTRL:   rdata = {28'h0, ctrl};
                OFF_PRESET: rdata = preset;
                OFF_COUNT:  rdata = count;
                default:    rdata = 32'h0;
            endcase
        end
    end

    assign irq = int_flag & ctrl.im;

endmodule
